// File: rtl/pdm_capture_if.sv
// Stereo PCM output stream of the PDM capture sequencer.
//
// Handshake: the master raises out_valid with out_left/out_right; a word
// transfers on every clk edge where out_valid && out_ready are both 1.
// While out_valid is 1 and out_ready is 0, the master holds the data
// stable. out_ready may change at any time and does not depend on
// out_valid.
//
// Signals:
//   out_valid  master -> slave  stereo sample available
//   out_ready  slave -> master  consumer accepts sample
//   out_left   master -> slave  signed left sample, W bits
//   out_right  master -> slave  signed right sample, W bits
interface pdm_capture_if #(
    parameter int W = 16
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_left;
    logic [W-1:0] out_right;

    modport master (
        output out_valid,
        output out_left,
        output out_right,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_left,
        input  out_right,
        output out_ready
    );
endinterface

// File: rtl/pdm_capture_ctrl.sv
// Sequencer for the stereo PDM microphone front end.
//
// Generates the PDM microphone clock and the left/right CIC integrator
// enables, a shared comb-stage enable once per PCM sample, discards the
// CIC settling samples after every start, applies a saturating left-shift
// gain and presents each stereo pair on a valid/ready stream with a
// sticky overrun flag. Nothing toggles until software issues start.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   start, stop    one-cycle pulses; stop takes effect at the next PDM
//                  period boundary
//   gain_shift     left shift applied to PCM, sampled at capture strobe
//   clk_pdm        PDM microphone clock
//   en_left        one-cycle enable to left CIC integrators
//   en_right       one-cycle enable to right CIC integrators
//   en_pcm         one-cycle enable to both CIC comb stages
//   pcm_left/right signed CIC outputs
//   out_if         stereo output stream (master side)
//   overrun        sticky: a sample was dropped; overrun_clr clears it
//   busy           state != IDLE
//   state_dbg      current FSM state encoding (debug)
module pdm_capture_ctrl #(
    parameter int W       = 16,
    parameter int CNT_MAX = 19,
    parameter int DECIM   = 64,
    parameter int WARMUP  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [2:0]   gain_shift,
    output logic         clk_pdm,
    output logic         en_left,
    output logic         en_right,
    output logic         en_pcm,
    input  logic [W-1:0] pcm_left,
    input  logic [W-1:0] pcm_right,
    pdm_capture_if.master out_if,
    output logic         overrun,
    input  logic         overrun_clr,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    localparam int CW   = $clog2(CNT_MAX + 1);
    localparam int DW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int HALF = (CNT_MAX + 1) / 2;
    localparam int GW   = W + 7;

    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_EN_L = CW'(HALF - 3);
    localparam logic [CW-1:0] CNT_EN_R = CW'(CNT_MAX - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DECIM - 1);
    localparam logic [3:0]    WARM_N   = 4'(WARMUP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div;
    logic [3:0]    warm_cnt;
    logic          stop_pending;
    logic          period_end;
    logic          to_idle;

    // The capture strobe carries the mode (deliver vs. discard) that was
    // current when its en_pcm was issued, so a strobe landing after a
    // stop has already returned the FSM to IDLE is still handled.
    logic          pcm_tag_run;
    logic          strobe;
    logic          strobe_run;

    logic          out_valid_q;
    logic [W-1:0]  out_left_q;
    logic [W-1:0]  out_right_q;
    logic [W-1:0]  gained_left;
    logic [W-1:0]  gained_right;

    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;
    assign period_end = (cnt == CNT_LAST);
    assign to_idle    = busy && (state_n == S_IDLE);

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_left  = out_left_q;
    assign out_if.out_right = out_right_q;

    // Shift at W+7 bits (no bits lost for shifts up to 7), then clamp:
    // the value fits in W bits only if bits [GW-1:W-1] are all equal.
    function automatic logic [W-1:0] gain_sat(input logic [W-1:0] x,
                                              input logic [2:0]   sh);
        logic [GW-1:0] ext;
        logic [GW-1:0] shifted;
        logic [GW-W:0] upper;
        ext     = {{7{x[W-1]}}, x};
        shifted = ext << sh;
        upper   = shifted[GW-1:W-1];
        if (upper == '0 || upper == '1) begin
            gain_sat = shifted[W-1:0];
        end else if (shifted[GW-1]) begin
            gain_sat = {1'b1, {(W-1){1'b0}}};
        end else begin
            gain_sat = {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    always_comb begin
        gained_left  = gain_sat(pcm_left, gain_shift);
        gained_right = gain_sat(pcm_right, gain_shift);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                // stop in the same cycle as start cancels it
                if (start && !stop) state_n = S_WARMUP;
            end
            S_WARMUP: begin
                if (period_end && stop_pending) state_n = S_IDLE;
                else if (warm_cnt == WARM_N)     state_n = S_RUN;
            end
            S_RUN: begin
                if (period_end && stop_pending) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            div          <= '0;
            warm_cnt     <= '0;
            stop_pending <= 1'b0;
            clk_pdm      <= 1'b0;
            en_left      <= 1'b0;
            en_right     <= 1'b0;
            en_pcm       <= 1'b0;
            pcm_tag_run  <= 1'b0;
            strobe       <= 1'b0;
            strobe_run   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_left_q   <= '0;
            out_right_q  <= '0;
            overrun      <= 1'b0;
        end else begin
            state <= state_n;

            if (!busy || to_idle) begin
                cnt <= '0;
                div <= '0;
            end else if (period_end) begin
                cnt <= '0;
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (to_idle)            stop_pending <= 1'b0;
            else if (stop && busy)  stop_pending <= 1'b1;

            if (to_idle) begin
                warm_cnt <= '0;
            end else if (strobe && !strobe_run && warm_cnt != WARM_N) begin
                warm_cnt <= warm_cnt + 1'b1;
            end

            // Forced low on the way to IDLE so the mic clock is quiet
            // from the first idle cycle.
            if (!busy || to_idle)      clk_pdm <= 1'b0;
            else if (cnt == '0)        clk_pdm <= 1'b0;
            else if (cnt == CNT_HALF)  clk_pdm <= 1'b1;

            en_left     <= busy && (cnt == CNT_EN_L);
            en_right    <= busy && (cnt == CNT_EN_R);
            en_pcm      <= busy && period_end && (div == DIV_LAST);
            pcm_tag_run <= busy && period_end && (div == DIV_LAST) &&
                           (state == S_RUN);

            // comb output is valid one clk after en_pcm
            strobe     <= en_pcm;
            strobe_run <= pcm_tag_run;

            if (strobe && strobe_run) begin
                if (!out_valid_q || out_if.out_ready) begin
                    out_valid_q <= 1'b1;
                    out_left_q  <= gained_left;
                    out_right_q <= gained_right;
                end
            end else if (out_valid_q && out_if.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // set beats clear when both happen together
            if (strobe && strobe_run && out_valid_q && !out_if.out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
